// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-sequencer types and constants
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } seq_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - PC+4 / branch-target adder with sign extension and word alignment
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0]   pc,
    input  logic                    branch_taken,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    output logic [ADDR_WIDTH-1:0]   next_pc
);

    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] offset_ext;
    logic [ADDR_WIDTH-1:0] target;

    assign pc_plus4   = pc + ADDR_WIDTH'(INSTR_BYTES);
    // Word offset becomes a byte offset; sums wrap modulo 2^ADDR_WIDTH.
    assign offset_ext = {{(ADDR_WIDTH-OFFSET_WIDTH){branch_offset[OFFSET_WIDTH-1]}}, branch_offset} << 2;
    assign target     = pc_plus4 + offset_ext;
    assign next_pc    = branch_taken ? {target[ADDR_WIDTH-1:2], 2'b00} : pc_plus4;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and req/ack instruction fetch sequencer
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    OFFSET_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch_mux_ctrl,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    input  logic                    stall,
    output logic                    imem_req,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    input  logic                    imem_ack,
    input  logic [31:0]             imem_rdata,
    output logic                    instr_valid,
    output logic [31:0]             instr_out,
    output logic [ADDR_WIDTH-1:0]   instr_pc,
    output logic [31:0]             retire_count
);

    seq_state_t            state;
    seq_state_t            state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  do_capture;
    logic                  do_release;

    next_pc_calc #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_next_pc_calc (
        .pc            (pc),
        .branch_taken  (branch_mux_ctrl),
        .branch_offset (branch_offset),
        .next_pc       (next_pc)
    );

    // pc only moves on release, so it doubles as the stable fetch address.
    assign imem_addr = pc;

    always_comb begin
        state_next = state;
        do_capture = 1'b0;
        do_release = 1'b0;
        case (state)
            BOOT: state_next = FETCH;
            FETCH: begin
                if (imem_req && imem_ack) begin
                    do_capture = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    do_release = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            instr_out    <= '0;
            instr_pc     <= '0;
            retire_count <= '0;
        end else begin
            state    <= state_next;
            imem_req <= (state_next == FETCH);
            if (do_capture) begin
                instr_out   <= imem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
            end
            if (do_release) begin
                instr_valid  <= 1'b0;
                pc           <= next_pc;
                retire_count <= retire_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed table-driven bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch_mux_ctrl = 1'b0;
    logic [15:0] branch_offset = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] retire_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pc_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .branch_mux_ctrl (branch_mux_ctrl),
        .branch_offset   (branch_offset),
        .stall           (stall),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .retire_count    (retire_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          lat;
        int          stall_n;
        logic        br;
        logic [15:0] off;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first ISSUE cycle.
    task automatic do_fetch(input int lat, input logic [31:0] data, input logic [31:0] exp_addr);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req_seen", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, exp_addr);
        for (int k = 0; k < lat; k++) begin
            stall = 1'b1;
            branch_mux_ctrl = 1'b1;
            @(negedge clk);
            chk("fetch_req_hold", {31'd0, imem_req}, 32'd1);
            chk("fetch_addr_hold", imem_addr, exp_addr);
            chk("fetch_no_early_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ack = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("cap_valid", {31'd0, instr_valid}, 32'd1);
        chk("cap_instr", instr_out, data);
        chk("cap_pc", instr_pc, exp_addr);
        chk("cap_req_drop", {31'd0, imem_req}, 32'd0);
    endtask

    initial begin
        int last_cap;
        logic [31:0] data;

        vecs[0]  = '{1, 0, 1'b0, 16'h0000, 32'h0000_0000, 32'h0000_0004};
        vecs[1]  = '{1, 0, 1'b0, 16'h0000, 32'h0000_0004, 32'h0000_0008};
        vecs[2]  = '{1, 0, 1'b0, 16'h0000, 32'h0000_0008, 32'h0000_000C};
        vecs[3]  = '{1, 0, 1'b0, 16'h0000, 32'h0000_000C, 32'h0000_0010};
        vecs[4]  = '{1, 0, 1'b1, 16'h0003, 32'h0000_0010, 32'h0000_0020};
        vecs[5]  = '{1, 0, 1'b1, 16'hFFFB, 32'h0000_0020, 32'h0000_0010};
        vecs[6]  = '{1, 0, 1'b1, 16'hFFFB, 32'h0000_0010, 32'h0000_0000};
        vecs[7]  = '{1, 5, 1'b0, 16'h0002, 32'h0000_0000, 32'h0000_0004};
        vecs[8]  = '{1, 5, 1'b1, 16'h0002, 32'h0000_0004, 32'h0000_0010};
        vecs[9]  = '{4, 0, 1'b0, 16'h0000, 32'h0000_0010, 32'h0000_0014};
        vecs[10] = '{1, 0, 1'b1, 16'hFFF8, 32'h0000_0014, 32'hFFFF_FFF8};
        vecs[11] = '{1, 0, 1'b0, 16'h0000, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
        vecs[12] = '{1, 0, 1'b0, 16'h0000, 32'hFFFF_FFFC, 32'h0000_0000};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_retire", retire_count, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("boot_no_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        chk("first_req", {31'd0, imem_req}, 32'd1);

        last_cap = 0;
        for (int i = 0; i < 13; i++) begin
            do_fetch(vecs[i].lat, 32'hA500_0000 | 32'(i), vecs[i].exp_pc);
            if (i > 0 && vecs[i].lat == 1 && vecs[i-1].lat == 1 && vecs[i-1].stall_n == 0)
                chk("issue_period", 32'(cyc - last_cap), 32'd3);
            last_cap = cyc;
            for (int s = 0; s < vecs[i].stall_n; s++) begin
                stall = 1'b1;
                branch_mux_ctrl = (s % 2 == 0) ? ~vecs[i].br : vecs[i].br;
                branch_offset = 16'h0100;
                @(negedge clk);
                chk("stall_instr", instr_out, 32'hA500_0000 | 32'(i));
                chk("stall_pc", instr_pc, vecs[i].exp_pc);
                chk("stall_no_req", {31'd0, imem_req}, 32'd0);
                chk("stall_retire", retire_count, 32'(i));
            end
            stall = 1'b0;
            branch_mux_ctrl = vecs[i].br;
            branch_offset = vecs[i].off;
            @(negedge clk);
            branch_mux_ctrl = 1'b1;
            branch_offset = 16'h7FFF;
            chk("rel_valid", {31'd0, instr_valid}, 32'd0);
            chk("rel_req", {31'd0, imem_req}, 32'd1);
            chk("rel_next_addr", imem_addr, vecs[i].exp_next);
            chk("rel_retire", retire_count, 32'(i + 1));
        end

        // retire_count wrap
        do_fetch(1, 32'h1234_5678, 32'h0000_0000);
        stall = 1'b1;
        @(negedge clk);
        force dut.retire_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retire_count;
        chk("retire_forced", retire_count, 32'hFFFF_FFFF);
        stall = 1'b0;
        branch_mux_ctrl = 1'b0;
        @(negedge clk);
        chk("retire_wrap", retire_count, 32'd0);
        chk("wrap_next_addr", imem_addr, 32'h0000_0004);

        // Reset mid-FETCH, spurious ack during BOOT
        chk("mid_fetch_req", {31'd0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req_drop", {31'd0, imem_req}, 32'd0);
        chk("async_addr", imem_addr, 32'd0);
        chk("async_retire", retire_count, 32'd0);
        chk("async_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_instr", instr_out, 32'd0);
        chk("async_pc", instr_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("boot_ack_ignored", {31'd0, instr_valid}, 32'd0);
        chk("boot_ack_instr", instr_out, 32'd0);
        chk("post_boot_req", {31'd0, imem_req}, 32'd1);
        data = 32'hC0DE_0001;
        do_fetch(1, data, 32'h0000_0000);
        stall = 1'b0;
        branch_mux_ctrl = 1'b0;
        @(negedge clk);
        chk("post_reset_next", imem_addr, 32'h0000_0004);
        chk("post_reset_retire", retire_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and fetch sequencer for the CPU. It consumes branch_mux_ctrl from the branch gate and the sign-extended branch offset, and selects the next PC as either PC+4 or the branch target. It fetches each instruction over a req/ack handshake with instruction memory, then presents it to decode until the pipeline releases it.

Parameters:
ADDR_WIDTH, 32, PC and instruction-memory address width in bits
RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned
OFFSET_WIDTH, 16, width of the signed word offset supplied with a branch

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
branch_mux_ctrl  input  1  branch taken (branch ctrl AND ALU zero result), sampled only at release
branch_offset  input  OFFSET_WIDTH  signed word offset relative to PC+4
stall  input  1  decode/execute not ready; holds the current instruction
imem_req  output  1  fetch request, held high until ack
imem_addr  output  ADDR_WIDTH  fetch byte address, bits [1:0] always 0
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  fetched instruction word
instr_valid  output  1  instr_out/instr_pc hold a valid instruction
instr_out  output  32  registered instruction word
instr_pc  output  ADDR_WIDTH  address of instr_out
retire_count  output  32  number of instructions released, wraps

Behaviour:
- Single clock. Reset is asynchronous, active-low, with synchronous release.
- Reset values:
  - state=BOOT; pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr_out=0, instr_pc=0, retire_count=0.
- State BOOT:
  - Lasts one cycle after rst_n deasserts, then goes to FETCH.
- State FETCH:
  - imem_req=1 (registered); imem_addr=pc.
  - The address is stable while req is high.
  - On imem_ack: capture instr_out<=imem_rdata and instr_pc<=pc, set instr_valid<=1, go to ISSUE.
  - imem_ack while req=0 is ignored.
  - imem_req deasserts in the cycle after ack.
- State ISSUE:
  - instr_valid=1 and instr_out is stable.
  - While stall=1: hold everything. branch_mux_ctrl is ignored.
  - On the first cycle with stall=0 (release):
    - retire_count += 1.
    - If branch_mux_ctrl=1: pc <= pc + 4 + (sign_extend(branch_offset) << 2).
    - Otherwise: pc <= pc + 4.
    - instr_valid <= 0; go to FETCH.
- Arithmetic:
  - All PC sums are modulo 2^ADDR_WIDTH; wrap is silent.
  - The branch target's low 2 bits are forced to 0.
- Latency:
  - Minimum 3 cycles per instruction with zero-wait memory and no stall: FETCH(req) -> ack -> ISSUE.
  - First imem_req is asserted 1 cycle after reset release.
- Boundaries:
  - branch_mux_ctrl asserted outside ISSUE/release has no effect.
  - stall asserted in FETCH has no effect; the fetch completes and stall is then honoured in ISSUE.
  - pc=0xFFFFFFFC with no branch wraps to 0x00000000.
  - Negative offset producing an underflow wraps modulo 2^ADDR_WIDTH.
  - retire_count wraps 0xFFFFFFFF -> 0.
  - Reset mid-FETCH: imem_req drops immediately (asynchronous); a late imem_ack arriving during BOOT is ignored.
- No combinational path from any input to any output.

Decomposition:
- Shared package cpu_pkg holds:
  - state typedef {BOOT, FETCH, ISSUE};
  - constant INSTR_BYTES=4;
  - constant RESET_PC default.
- One natural sub-module: next_pc_calc (combinational PC+4 / branch-target adder with sign extension and alignment masking).
- The sequencer FSM, registers and counter stay in pc_sequencer.

Test Plan:
1. Reset release, zero-wait memory, stall=0 -> imem_addr sequence 0x0, 0x4, 0x8. instr_valid pulses every 3rd cycle. retire_count=3 after the third release.
2. At instr_pc=0x10, branch_mux_ctrl=1, branch_offset=3 -> next imem_addr=0x20. With offset=-5 -> next imem_addr=0x00.
3. stall=1 for 5 cycles in ISSUE, with branch_mux_ctrl toggling -> instr_out/instr_pc unchanged. No imem_req. Next PC decided by branch_mux_ctrl in the release cycle only.
4. imem_ack delayed 4 cycles -> imem_req and imem_addr held stable throughout. Capture occurs on the ack cycle.
5. pc=0xFFFFFFFC, no branch -> next imem_addr=0x00000000. Force retire_count=0xFFFFFFFF, release -> 0.
6. Assert rst_n=0 mid-FETCH -> imem_req=0 in the same cycle, all outputs at reset values. A spurious ack in BOOT is ignored. First request goes to RESET_PC.
